// File: rtl/lease_arbiter_pkg.sv
// Shared types, default parameters and pointer helper for the lease arbiter.
package lease_arbiter_pkg;

  localparam int N_DEF         = 3;
  localparam int IDW_DEF       = 2;
  localparam int LEASE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  // Successor of idx in a ring of n clients.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lease_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit scanning ptr, ptr+1, ... mod N.
module lease_arbiter_rr_pick #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] w_cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
      w_cand = (w_cand == IDW'(N - 1)) ? '0 : w_cand + IDW'(1);
    end
  end

endmodule

// File: rtl/lease_arbiter.sv
// Central round-robin req/ack lease arbiter for one shared resource.
// Optional lease expiry with revoke pulse is built when LEASE_TIMEOUT_EN is defined.
module lease_arbiter
  import lease_arbiter_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int IDW       = IDW_DEF,
  parameter int LEASE_MAX = LEASE_MAX_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   ack,
  output logic [IDW-1:0] owner,
  output logic           busy,
  output logic           revoke
);

  if (N < 2 || N > 8 || (2 ** IDW) < N || LEASE_MAX < 1) begin : g_param_check
    $error("lease_arbiter: illegal N/IDW/LEASE_MAX combination");
  end

  arb_state_t     r_state, w_state_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [IDW-1:0] r_owner, w_owner_nxt;
  logic [N-1:0]   r_ack, w_ack_nxt;
  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic           w_req_own;
  logic [IDW-1:0] w_ptr_after;

`ifdef LEASE_TIMEOUT_EN
  localparam int CW = $clog2(LEASE_MAX + 1);
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           r_revoke, w_revoke_nxt;
`endif

  lease_arbiter_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_req_own   = req[r_owner];
  assign w_ptr_after = IDW'(next_ptr(32'(r_owner), unsigned'(N)));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_ack_nxt   = r_ack;
`ifdef LEASE_TIMEOUT_EN
    w_cnt_nxt    = r_cnt;
    w_revoke_nxt = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_idx;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_req_own) begin
          w_ack_nxt          = '0;
          w_ack_nxt[r_owner] = 1'b1;
          w_state_nxt        = BUSY;
`ifdef LEASE_TIMEOUT_EN
          w_cnt_nxt = '0;
`endif
        end else begin
          // Request withdrawn before the grant landed: skip this client.
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_after;
        end
      end
      BUSY: begin
        if (!w_req_own) begin
          w_ack_nxt   = '0;
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_after;
        end
`ifdef LEASE_TIMEOUT_EN
        else if (r_cnt == CW'(LEASE_MAX - 1)) begin
          w_ack_nxt    = '0;
          w_revoke_nxt = 1'b1;
          w_state_nxt  = RECOVER;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
      end
`ifdef LEASE_TIMEOUT_EN
      RECOVER: begin
        if (!w_req_own) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_after;
        end
      end
`endif
      default: begin
        w_ack_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

`ifdef LEASE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_revoke <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_revoke <= w_revoke_nxt;
    end
  end

  assign revoke = r_revoke;
`else
  assign revoke = 1'b0;
`endif

  assign ack   = r_ack;
  assign owner = r_owner;
  assign busy  = (r_state != IDLE);

endmodule

// File: doc/lease_arbiter.md
Name: lease_arbiter

Overview:
- N-client mutual-exclusion arbiter for one shared resource, using a four-phase req/ack handshake.
- Uses round-robin selection with a rotating priority pointer.
- Replaces the distributed token-passing controller ring with a single central sequencer.
- Sits between client request FSMs and the shared resource; exports the current owner index for resource muxing.

Parameters:
- N, 3, number of requesting clients (2..8)
- IDW, 2, width of the owner index; must satisfy 2**IDW >= N
- LEASE_MAX, 8, maximum BUSY cycles per grant; used only when LEASE_TIMEOUT_EN is defined

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N  per-client request level; held high until the client releases
- ack  output  N  per-client grant, registered, at most one bit high (onehot0)
- owner  output  IDW  index of the client currently being served; valid when busy=1
- busy  output  1  high in GRANT, BUSY and RECOVER states
- revoke  output  1  one-cycle pulse on lease expiry; tied 0 when the feature is compiled out

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, owner=0, ack=0, busy=0, revoke=0, lease count=0.
  - Reset asserted mid-grant drops ack on the next edge; no release handshake is required.
- States: IDLE, GRANT, BUSY, RECOVER.
- IDLE:
  - Pick the first i with req[i]=1, scanning ptr, ptr+1, ... (mod N).
  - If one is found: owner<=i, state<=GRANT.
  - Otherwise stay in IDLE.
- GRANT (one cycle):
  - If req[owner]=1: ack[owner]<=1, state<=BUSY.
  - If req[owner]=0 (request withdrawn): state<=IDLE, ptr<=owner+1 mod N, no ack is ever issued.
- BUSY:
  - If req[owner]=0: ack<=0, state<=IDLE, ptr<=(owner+1) mod N.
- Latency: req rising sampled at edge t (IDLE) -> GRANT after t -> ack high after edge t+1 (two edges).
- Release latency: req falling sampled at edge t -> ack low after edge t.
- Re-arbitration: the earliest next grant needs one IDLE cycle, so two owners' acks are never adjacent. A one-cycle ack gap is guaranteed.
- Pointer wrap: from owner=N-1, ptr becomes 0. Indices at or above N are never selected.
- Requests from non-owners during GRANT/BUSY/RECOVER are ignored. Their req bits must stay high to be served later.
- Fairness:
  - A continuously requesting client is granted within N-1 other grants.
  - With all clients requesting, grant order is 0,1,...,N-1,0,...
- owner holds its value outside busy (last owner).

Optional Feature:
- Macro: LEASE_TIMEOUT_EN
- Defined:
  - A lease counter clears on entry to BUSY and increments each BUSY cycle.
  - When count==LEASE_MAX-1 and req[owner]=1: ack<=0, revoke<=1 for one cycle, state<=RECOVER.
  - RECOVER waits for req[owner]=0, then goes to IDLE with ptr<=owner+1.
  - A release that coincides with expiry is a normal release: no revoke pulse.
- Not defined: no counter, no RECOVER state, revoke tied to 0, a lease is unbounded.

Decomposition:
- Package lease_arbiter_pkg:
  - typedef arb_state_t {IDLE, GRANT, BUSY, RECOVER}
  - function next_ptr
  - localparam defaults
- Sub-module rr_pick:
  - Combinational rotating-priority picker.
  - Inputs: req[N], ptr. Outputs: found, idx.
  - Reusable by other schedulers in the same codebase.
- Top holds the FSM, ack register and lease counter.

Test Plan:
- Reset, then req=3'b001 from cycle 2 -> owner=0, busy=1 after edge 2, ack=3'b001 after edge 3; drop req[0] -> ack=0 and busy=0 one edge later, ptr=1.
- req=3'b111 held, each client drops its req 2 cycles after its ack -> ack sequence 001,000,010,000,100,000,001; never two bits high and never adjacent non-zero acks.
- ptr=2 and req=3'b011 -> owner=0 (wrap), not 1.
- req[1] pulses high for exactly one cycle (IDLE->GRANT, then low in GRANT) -> no ack, return to IDLE, ptr=2.
- reset asserted while ack=3'b010 in BUSY -> ack=0, state IDLE and ptr=0 after the edge; req=3'b010 still high -> regranted via GRANT two edges after reset release.
- LEASE_TIMEOUT_EN with LEASE_MAX=4, req[0] held -> ack[0] high 4 cycles, then ack=0 with revoke=1 for one cycle; client 1 is not granted until req[0] drops. Without the macro, ack[0] stays high indefinitely and revoke=0.
